// File: rtl/timestamp_event_scheduler.sv
// rtl/timestamp_event_scheduler.sv - edge capture, pending/overflow tracking and round-robin event offer
module timestamp_event_scheduler #(
  parameter int         SOURCES  = 8,
  parameter logic [9:0] BASE_ADR = 10'h000
) (
  input  logic               clk_peri,
  input  logic               reset,
  input  logic               access_peri,
  input  logic [9:0]         addr_peri,
  input  logic               wr_peri,
  input  logic [17:0]        do_peri,
  output logic [17:0]        di_peri,
  input  logic [SOURCES-1:0] event_in,
  output logic               ev_valid,
  output logic [4:0]         ev_id,
  input  logic               ev_ready
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [SOURCES-1:0] enable_q, enable_d;
  logic [SOURCES-1:0] pending_q, pending_d;
  logic [SOURCES-1:0] overflow_q, overflow_d;
  logic [SOURCES-1:0] last_q, last_d;
  logic [3:0]         ptr_q, ptr_d;
  logic [3:0]         grant_q, grant_d;
  logic               rd_q, rd_d;
  logic [2:0]         radr_q, radr_d;

  logic               sel, wr_enable, wr_ovf_clr, flush, accept;
  logic [SOURCES-1:0] grant_mask, offer_mask, acc_mask, keep_mask, rise, rise_kept, ovf_clr;
  logic [3:0]         next_idx;
  logic               next_found;

  assign sel        = access_peri & (addr_peri[9:3] == BASE_ADR[9:3]);
  assign wr_enable  = sel & wr_peri & (addr_peri[2:0] == 3'd0);
  assign wr_ovf_clr = sel & wr_peri & (addr_peri[2:0] == 3'd2);
  assign flush      = sel & wr_peri & (addr_peri[2:0] == 3'd3) & do_peri[0];
  assign accept     = (state_q == OFFER) & ev_ready;

  always_comb begin
    for (int i = 0; i < SOURCES; i++) begin
      grant_mask[i] = (grant_q == 4'(i));
    end
  end

  // Round-robin pick: indices above ptr first, then wrap to 0..ptr.
  always_comb begin
    next_found = 1'b0;
    next_idx   = ptr_q;
    for (int i = 0; i < SOURCES; i++) begin
      if (!next_found && pending_q[i] && (4'(i) > ptr_q)) begin
        next_found = 1'b1;
        next_idx   = 4'(i);
      end
    end
    for (int i = 0; i < SOURCES; i++) begin
      if (!next_found && pending_q[i] && (4'(i) <= ptr_q)) begin
        next_found = 1'b1;
        next_idx   = 4'(i);
      end
    end
  end

  // A flush keeps only the source currently on offer, both for held and new events.
  always_comb begin
    offer_mask = (state_q == OFFER) ? grant_mask : '0;
    acc_mask   = accept ? grant_mask : '0;
    keep_mask  = flush ? offer_mask : '1;
    rise       = event_in & ~last_q & enable_q;
    rise_kept  = rise & keep_mask;
    ovf_clr    = wr_ovf_clr ? do_peri[SOURCES-1:0] : '0;
    pending_d  = (pending_q & ~acc_mask & keep_mask) | rise_kept;
    overflow_d = (overflow_q & ~ovf_clr) | (rise_kept & pending_q & ~acc_mask);
    enable_d   = wr_enable ? do_peri[SOURCES-1:0] : enable_q;
    last_d     = event_in;
    rd_d       = sel & ~wr_peri;
    radr_d     = addr_peri[2:0];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (next_found && !flush) begin
          grant_d = next_idx;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (ev_ready) begin
          ptr_d   = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ev_valid = (state_q == OFFER);
    ev_id    = 5'd0;
    if (state_q == OFFER) begin
      ev_id = 5'(grant_q) + 5'd1;
    end
  end

  always_comb begin
    di_peri = 18'd0;
    if (rd_q) begin
      case (radr_q)
        3'd0:    di_peri = 18'(enable_q);
        3'd1:    di_peri = 18'(pending_q);
        3'd2:    di_peri = 18'(overflow_q);
        default: di_peri = 18'd0;
      endcase
    end
  end

  always_ff @(posedge clk_peri) begin
    if (reset) begin
      state_q    <= IDLE;
      enable_q   <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
      last_q     <= '1;
      ptr_q      <= 4'(SOURCES - 1);
      grant_q    <= 4'd0;
      rd_q       <= 1'b0;
      radr_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      last_q     <= last_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      rd_q       <= rd_d;
      radr_q     <= radr_d;
    end
  end

endmodule

// File: tb/tb_timestamp_event_scheduler.sv
// tb/tb_timestamp_event_scheduler.sv - register table, directed corner sequences and random run against a reference model
module tb_timestamp_event_scheduler;

  localparam int         S    = 8;
  localparam logic [9:0] BASE = 10'h000;

  logic         clk_peri = 1'b0;
  logic         reset = 1'b1;
  logic         access_peri = 1'b0;
  logic [9:0]   addr_peri = 10'd0;
  logic         wr_peri = 1'b0;
  logic [17:0]  do_peri = 18'd0;
  logic [17:0]  di_peri;
  logic [S-1:0] event_in = '0;
  logic         ev_valid;
  logic [4:0]   ev_id;
  logic         ev_ready = 1'b0;

  int total = 0;
  int bad = 0;

  timestamp_event_scheduler #(.SOURCES(S), .BASE_ADR(BASE)) dut (
    .clk_peri(clk_peri), .reset(reset), .access_peri(access_peri), .addr_peri(addr_peri),
    .wr_peri(wr_peri), .do_peri(do_peri), .di_peri(di_peri), .event_in(event_in),
    .ev_valid(ev_valid), .ev_id(ev_id), .ev_ready(ev_ready)
  );

  always #5 clk_peri = ~clk_peri;

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [17:0] data;
    logic [17:0] exp;
  } reg_vec_t;

  reg_vec_t tbl[14];

  task automatic tick();
    @(posedge clk_peri);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [9:0] a, input logic [17:0] d);
    access_peri = 1'b1; wr_peri = 1'b1; addr_peri = a; do_peri = d;
    tick();
    access_peri = 1'b0; wr_peri = 1'b0; do_peri = 18'd0;
  endtask

  task automatic cpu_read(input logic [9:0] a, output logic [17:0] d);
    access_peri = 1'b1; wr_peri = 1'b0; addr_peri = a;
    tick();
    access_peri = 1'b0;
    d = di_peri;
  endtask

  task automatic read_check(input string name, input logic [9:0] a, input logic [17:0] exp);
    logic [17:0] d;
    cpu_read(a, d);
    check(name, d, exp);
  endtask

  task automatic expect_offer(input string name, input logic [4:0] id);
    check({name, " valid"}, ev_valid, 1);
    check({name, " id"}, ev_id, id);
  endtask

  task automatic expect_idle(input string name);
    check({name, " valid"}, ev_valid, 0);
    check({name, " id"}, ev_id, 0);
  endtask

  task automatic accept_offer();
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Reference model: per-source flags plus a modulo round-robin search.
  bit m_en[S], m_pend[S], m_ovf[S], m_last[S];
  int m_ptr, m_grant, m_radr;
  bit m_offer, m_rd;

  task automatic model_reset();
    for (int i = 0; i < S; i++) begin
      m_en[i] = 0; m_pend[i] = 0; m_ovf[i] = 0; m_last[i] = 1;
    end
    m_ptr = S - 1; m_grant = 0; m_offer = 0; m_rd = 0; m_radr = 0;
  endtask

  function automatic logic [17:0] model_reg(input int off);
    logic [17:0] v;
    v = 18'd0;
    for (int i = 0; i < S; i++) begin
      if (off == 0) v[i] = m_en[i];
      if (off == 1) v[i] = m_pend[i];
      if (off == 2) v[i] = m_ovf[i];
    end
    return v;
  endfunction

  task automatic model_step();
    bit sel, wr, flush, acc, rise, mine, taken;
    int off;
    bit np[S];
    bit no[S];
    if (reset) begin
      model_reset();
      return;
    end
    sel   = access_peri && (int'(addr_peri) / 8 == int'(BASE) / 8);
    off   = int'(addr_peri) % 8;
    wr    = sel && wr_peri;
    flush = wr && off == 3 && do_peri[0];
    acc   = m_offer && ev_ready;
    for (int i = 0; i < S; i++) begin
      rise  = event_in[i] && !m_last[i] && m_en[i];
      mine  = m_offer && m_grant == i;
      taken = acc && m_grant == i;
      if (flush && !mine) rise = 0;
      np[i] = m_pend[i] && !taken && !(flush && !mine);
      no[i] = m_ovf[i] && !(wr && off == 2 && do_peri[i]);
      if (rise) begin
        np[i] = 1;
        if (m_pend[i] && !taken) no[i] = 1;
      end
    end
    if (m_offer) begin
      if (ev_ready) begin
        m_ptr = m_grant;
        m_offer = 0;
      end
    end else if (!flush) begin
      for (int k = 1; k <= S; k++) begin
        if (m_pend[(m_ptr + k) % S]) begin
          m_grant = (m_ptr + k) % S;
          m_offer = 1;
          break;
        end
      end
    end
    for (int i = 0; i < S; i++) begin
      m_pend[i] = np[i];
      m_ovf[i]  = no[i];
      m_last[i] = event_in[i];
      if (wr && off == 0) m_en[i] = do_peri[i];
    end
    m_rd   = sel && !wr_peri;
    m_radr = off;
  endtask

  initial begin
    logic [17:0] d;
    logic [23:0] exp_out;

    tbl[0]  = '{1'b1, 10'h000, 18'h3FFFF, 18'h0};
    tbl[1]  = '{1'b0, 10'h000, 18'h0,     18'h0FF};
    tbl[2]  = '{1'b0, 10'h003, 18'h0,     18'h0};
    tbl[3]  = '{1'b1, 10'h005, 18'h3FFFF, 18'h0};
    tbl[4]  = '{1'b0, 10'h005, 18'h0,     18'h0};
    tbl[5]  = '{1'b1, 10'h008, 18'h0,     18'h0};
    tbl[6]  = '{1'b0, 10'h000, 18'h0,     18'h0FF};
    tbl[7]  = '{1'b0, 10'h008, 18'h0,     18'h0};
    tbl[8]  = '{1'b1, 10'h000, 18'h000A5, 18'h0};
    tbl[9]  = '{1'b0, 10'h000, 18'h0,     18'h0A5};
    tbl[10] = '{1'b0, 10'h001, 18'h0,     18'h0};
    tbl[11] = '{1'b0, 10'h002, 18'h0,     18'h0};
    tbl[12] = '{1'b1, 10'h000, 18'h0,     18'h0};
    tbl[13] = '{1'b0, 10'h007, 18'h0,     18'h0};

    do_reset();
    expect_idle("reset");
    check("reset di_peri", di_peri, 0);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) begin
        cpu_write(tbl[i].addr, tbl[i].data);
      end else begin
        cpu_read(tbl[i].addr, d);
        check($sformatf("table read %0d", i), d, tbl[i].exp);
      end
    end

    // Single event: latency and pending clear on accept.
    cpu_write(10'h000, 18'h0FF);
    event_in = 8'h04; tick(); event_in = 8'h00;
    check("latency valid after 1", ev_valid, 0);
    tick();
    expect_offer("single", 5'd3);
    accept_offer();
    check("single accepted", ev_valid, 0);
    read_check("single pending", 10'h001, 18'h0);

    // Simultaneous events in round-robin order from ptr=7.
    do_reset();
    cpu_write(10'h000, 18'h0FF);
    event_in = 8'hA1; tick(); event_in = 8'h00; tick();
    expect_offer("rr first", 5'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_offer("rr hold", 5'd1);
    end
    accept_offer();
    check("rr bubble 1", ev_valid, 0);
    tick();
    expect_offer("rr second", 5'd6);
    accept_offer();
    check("rr bubble 2", ev_valid, 0);
    tick();
    expect_offer("rr third", 5'd8);
    accept_offer();
    tick();
    expect_idle("rr drained");

    // Overflow, write-1-to-clear, set beating clear, edge during accept.
    event_in = 8'h10; tick(); event_in = 8'h00; tick();
    expect_offer("ovf offer", 5'd5);
    event_in = 8'h10; tick(); event_in = 8'h00; tick();
    read_check("ovf set", 10'h002, 18'h010);
    cpu_write(10'h002, 18'h010);
    read_check("ovf cleared", 10'h002, 18'h0);
    event_in = 8'h10; cpu_write(10'h002, 18'h010); event_in = 8'h00;
    read_check("ovf set beats clear", 10'h002, 18'h010);
    expect_offer("ovf still offered", 5'd5);
    cpu_write(10'h002, 18'h010);
    event_in = 8'h10; ev_ready = 1'b1; tick(); event_in = 8'h00; ev_ready = 1'b0;
    check("edge on accept bubble", ev_valid, 0);
    read_check("edge on accept no ovf", 10'h002, 18'h0);
    expect_offer("edge on accept reoffer", 5'd5);
    read_check("edge on accept pending", 10'h001, 18'h010);
    accept_offer();
    read_check("after reoffer pending", 10'h001, 18'h0);

    // Level held high through reset is not an edge.
    event_in = 8'h02;
    do_reset();
    cpu_write(10'h000, 18'h0FF);
    tick(); tick();
    check("held high no event", ev_valid, 0);
    read_check("held high pending", 10'h001, 18'h0);
    event_in = 8'h00; tick();
    event_in = 8'h02; tick(); tick();
    expect_offer("reraised", 5'd2);
    accept_offer();
    event_in = 8'h00;

    // Flush while offering source 1 with source 3 pending; edge on source 5 is discarded.
    do_reset();
    cpu_write(10'h000, 18'h0FF);
    event_in = 8'h0A; tick(); event_in = 8'h00; tick();
    expect_offer("flush offer", 5'd2);
    event_in = 8'h20; cpu_write(10'h003, 18'h001); event_in = 8'h00;
    expect_offer("flush keeps offer", 5'd2);
    read_check("flush pending", 10'h001, 18'h002);
    accept_offer();
    check("flush accepted", ev_valid, 0);
    read_check("flush pending after", 10'h001, 18'h0);
    tick(); tick();
    expect_idle("flush no more");

    // Reset in the middle of an offer with overflow set.
    event_in = 8'h01; tick(); event_in = 8'h00; tick();
    event_in = 8'h01; tick(); event_in = 8'h00; tick();
    expect_offer("pre reset", 5'd1);
    reset = 1'b1; tick();
    expect_idle("mid reset");
    tick(); reset = 1'b0; tick();
    read_check("reset enable", 10'h000, 18'h0);
    read_check("reset pending", 10'h001, 18'h0);
    read_check("reset overflow", 10'h002, 18'h0);

    // Edge in the same cycle as the ENABLE write sees the old mask.
    event_in = 8'h04; cpu_write(10'h000, 18'h004); event_in = 8'h00;
    tick(); tick();
    check("old enable used", ev_valid, 0);
    event_in = 8'h04; tick(); event_in = 8'h00; tick();
    expect_offer("new enable used", 5'd3);
    accept_offer();

    // Random run against the reference model.
    for (int c = 0; c < 3000; c++) begin
      reset = (c == 0) || ($urandom_range(0, 199) == 0);
      ev_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < S; i++) begin
        if ($urandom_range(0, 5) == 0) event_in[i] = ~event_in[i];
      end
      access_peri = ($urandom_range(0, 9) < 4);
      wr_peri = 1'($urandom_range(0, 1));
      addr_peri = ($urandom_range(0, 7) == 0) ? 10'($urandom) : {BASE[9:3], 3'($urandom_range(0, 7))};
      do_peri = 18'($urandom);
      model_step();
      tick();
      exp_out = {m_offer ? 1'b1 : 1'b0, m_offer ? 5'(m_grant + 1) : 5'd0,
                 m_rd ? model_reg(m_radr) : 18'd0};
      check($sformatf("random cycle %0d {valid,id,di}", c), {ev_valid, ev_id, di_peri}, exp_out);
    end
    reset = 1'b0; access_peri = 1'b0; wr_peri = 1'b0; ev_ready = 1'b0; event_in = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
